// File: rtl/mem_ctrl_lc_if.sv
// Client and RAM-bus signals of the byte-serial memory controller.
// slave is the controller's view, master the clients'/RAM's view.
interface mem_ctrl_lc_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              lsb_rd_req;
  logic              lsb_wr_req;
  logic [2:0]        lsb_len;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_rd_done;
  logic [31:0]       lsb_rd_data;
  logic              lsb_wr_done;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  lsb_rd_req, lsb_wr_req, lsb_len, lsb_addr, lsb_wdata,
    output lsb_rd_done, lsb_rd_data, lsb_wr_done,
    input  if_req, if_addr,
    output if_done, if_data,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_rd_req, lsb_wr_req, lsb_len, lsb_addr, lsb_wdata,
    input  lsb_rd_done, lsb_rd_data, lsb_wr_done,
    output if_req, if_addr,
    input  if_done, if_data,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_lc.sv
// Byte-serial memory controller: fixed-priority arbitration of store/load/fetch,
// direct-mapped instruction cache with line fill and store-snoop invalidation.
module mem_ctrl_lc #(
  parameter int unsigned ICACHE_LINES = 16,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         io_buffer_full,
  input  logic         flush,
  mem_ctrl_lc_if.slave bus
);
  localparam int unsigned LB    = 4 * LINE_WORDS;
  localparam int unsigned LBITS = LB * 8;
  localparam int unsigned OFF_W = $clog2(LB);
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned CNT_W = OFF_W + 1;

  typedef enum logic [2:0] {IDLE, WRITE, LOAD, FILL, RESP} state_e;
  typedef enum logic [1:0] {CL_WR, CL_RD, CL_IF} client_e;

  state_e             state_q, state_d;
  client_e            sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, len_q, len_d, cnt_nx;
  logic [ADDR_W-1:0]  addr_q, addr_d, mem_a_q, mem_a_d;
  logic [31:0]        wdata_q, wdata_d, rd_data_q, rd_data_d, if_data_q, if_data_d;
  logic [LBITS-1:0]   fill_q, fill_d;
  logic [7:0]         mem_dout_q, mem_dout_d, hold_q, din_eff;
  logic               mem_wr_q, mem_wr_d, rdy_q, io_stall, line_we;
  logic [ICACHE_LINES-1:0] valid_q, valid_d;
  logic [LBITS-1:0]   line_q [ICACHE_LINES];
  logic [TAG_W-1:0]   tag_q  [ICACHE_LINES];
  logic [IDX_W-1:0]   if_idx, wr_idx, fill_idx;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  function automatic logic [31:0] word_of(input logic [LBITS-1:0] line,
                                          input logic [ADDR_W-1:0] a);
    logic [OFF_W-1:0] off;
    off = a[OFF_W-1:0] & ~OFF_W'(3);
    return 32'(line >> {off, 3'b000});
  endfunction

  function automatic logic [CNT_W-1:0] norm_len(input logic [2:0] l);
    case (l)
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  assign if_idx   = idx_of(bus.if_addr);
  assign wr_idx   = idx_of(mem_a_q);
  assign fill_idx = idx_of(addr_q);
  assign io_stall = (mem_a_q[17:16] == 2'b11) && io_buffer_full;
  // After a freeze the RAM has already moved on to the held address, so the
  // byte that was on mem_din at the first frozen edge is replayed once.
  assign din_eff  = rdy_q ? bus.mem_din : hold_q;

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q && rdy && !io_stall;
  assign bus.lsb_rd_data = rd_data_q;
  assign bus.if_data     = if_data_q;
  assign bus.lsb_wr_done = rdy && (state_q == RESP) && (sel_q == CL_WR);
  assign bus.lsb_rd_done = rdy && !flush && (state_q == RESP) && (sel_q == CL_RD);
  assign bus.if_done     = rdy && !flush && (state_q == RESP) && (sel_q == CL_IF);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    if_data_d  = if_data_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    line_we    = 1'b0;
    cnt_nx     = cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: if (!flush) begin
        cnt_d = '0;
        if (bus.lsb_wr_req) begin
          sel_d      = CL_WR;
          len_d      = norm_len(bus.lsb_len);
          addr_d     = bus.lsb_addr;
          wdata_d    = bus.lsb_wdata;
          mem_a_d    = bus.lsb_addr;
          mem_dout_d = bus.lsb_wdata[7:0];
          mem_wr_d   = 1'b1;
          state_d    = WRITE;
        end else if (bus.lsb_rd_req) begin
          sel_d     = CL_RD;
          len_d     = norm_len(bus.lsb_len);
          addr_d    = bus.lsb_addr;
          rd_data_d = '0;
          mem_a_d   = bus.lsb_addr;
          state_d   = LOAD;
        end else if (bus.if_req) begin
          sel_d  = CL_IF;
          addr_d = bus.if_addr;
          if (valid_q[if_idx] && tag_q[if_idx] == tag_of(bus.if_addr)) begin
            if_data_d = word_of(line_q[if_idx], bus.if_addr);
            state_d   = RESP;
          end else begin
            // Invalidate up front so an aborted fill never leaves a stale line.
            valid_d[if_idx] = 1'b0;
            fill_d          = '0;
            mem_a_d         = base_of(bus.if_addr);
            state_d         = FILL;
          end
        end
      end
      WRITE: if (!io_stall) begin
        if (valid_q[wr_idx] && tag_q[wr_idx] == tag_of(mem_a_q))
          valid_d[wr_idx] = 1'b0;
        if (cnt_nx == len_q) begin
          mem_wr_d = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d      = cnt_nx;
          mem_a_d    = addr_q + ADDR_W'(cnt_nx);
          mem_dout_d = 8'(wdata_q >> {cnt_nx, 3'b000});
        end
      end
      LOAD: if (flush) begin
        state_d = IDLE;
      end else begin
        if (cnt_q != '0)
          rd_data_d = rd_data_q | (32'(din_eff) << {cnt_q - CNT_W'(1), 3'b000});
        if (cnt_q == len_q) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx != len_q) mem_a_d = addr_q + ADDR_W'(cnt_nx);
        end
      end
      FILL: if (flush) begin
        state_d = IDLE;
      end else begin
        if (cnt_q != '0)
          fill_d = fill_q | (LBITS'(din_eff) << {cnt_q - CNT_W'(1), 3'b000});
        if (cnt_q == CNT_W'(LB)) begin
          line_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          if_data_d         = word_of(fill_d, addr_q);
          state_d           = RESP;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx != CNT_W'(LB)) mem_a_d = base_of(addr_q) + ADDR_W'(cnt_nx);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= CL_WR;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      if_data_q  <= '0;
      fill_q     <= '0;
      valid_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      rdy_q      <= 1'b1;
      hold_q     <= '0;
    end else begin
      rdy_q <= rdy;
      if (!rdy && rdy_q) hold_q <= bus.mem_din;
      if (rdy) begin
        state_q    <= state_d;
        sel_q      <= sel_d;
        cnt_q      <= cnt_d;
        len_q      <= len_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        rd_data_q  <= rd_data_d;
        if_data_q  <= if_data_d;
        fill_q     <= fill_d;
        valid_q    <= valid_d;
        mem_a_q    <= mem_a_d;
        mem_dout_q <= mem_dout_d;
        mem_wr_q   <= mem_wr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && line_we) begin
      line_q[fill_idx] <= fill_d;
      tag_q[fill_idx]  <= tag_of(addr_q);
    end
  end
endmodule

// File: tb/tb_mem_ctrl_lc.sv
// Directed bench for mem_ctrl_lc with a byte RAM model (one-cycle read latency).
module tb_mem_ctrl_lc;
  logic clk = 1'b0;
  logic rst, rdy, io_buffer_full, flush;
  int checks = 0;
  int failures = 0;

  mem_ctrl_lc_if #(.ADDR_W(32)) bus ();

  mem_ctrl_lc #(.ICACHE_LINES(16), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM: unwritten bytes read back as the low address byte.
  logic [7:0] ram [logic [31:0]];
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog [$];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a] = bus.mem_dout;
      wlog.push_back({bus.mem_a, bus.mem_dout});
    end
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  localparam int WRD = 0, RDD = 1, IFD = 2;

  function automatic logic dn(input int w);
    case (w)
      WRD:     return bus.lsb_wr_done;
      RDD:     return bus.lsb_rd_done;
      default: return bus.if_done;
    endcase
  endfunction

  // Cycles from now until the chosen done pulse; -1 when the budget expires.
  task automatic wait_done(input int w, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dn(w) && cyc < max);
    if (!dn(w)) cyc = -1;
  endtask

  task automatic test_reset();
    checks++; if (bus.mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr: got %0b want 0", bus.mem_wr); end
    checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    checks++; if (bus.mem_dout !== 8'h0) begin failures++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
    checks++; if ({bus.lsb_rd_done, bus.lsb_wr_done, bus.if_done} !== 3'b000) begin failures++; $display("FAIL reset_done: got %b want 000", {bus.lsb_rd_done, bus.lsb_wr_done, bus.if_done}); end
    checks++; if (bus.lsb_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", bus.lsb_rd_data); end
    checks++; if (bus.if_data !== 32'h0) begin failures++; $display("FAIL reset_if_data: got %h want 0", bus.if_data); end
  endtask

  task automatic test_fetch_fill();
    int cyc;
    logic [31:0] a0;
    bus.if_addr = 32'h0; bus.if_req = 1'b1;
    wait_done(IFD, 40, cyc); bus.if_req = 1'b0;
    checks++; if (cyc !== 18) begin failures++; $display("FAIL fill_latency: got %0d want 18", cyc); end
    checks++; if (bus.if_data !== 32'h03020100) begin failures++; $display("FAIL fill_data: got %h want 03020100", bus.if_data); end
    @(negedge clk);
    a0 = bus.mem_a; wlog.delete();
    bus.if_addr = 32'h4; bus.if_req = 1'b1;
    wait_done(IFD, 10, cyc); bus.if_req = 1'b0;
    checks++; if (cyc !== 1) begin failures++; $display("FAIL hit_latency: got %0d want 1", cyc); end
    checks++; if (bus.if_data !== 32'h07060504) begin failures++; $display("FAIL hit_data: got %h want 07060504", bus.if_data); end
    checks++; if (bus.mem_a !== a0 || wlog.size() != 0) begin failures++; $display("FAIL hit_bus_idle: mem_a %h want %h, writes %0d want 0", bus.mem_a, a0, wlog.size()); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wlog.delete();
    bus.lsb_addr = 32'h100; bus.lsb_wdata = 32'hDEADBEEF; bus.lsb_len = 3'd4;
    bus.lsb_wr_req = 1'b1; bus.if_addr = 32'h0; bus.if_req = 1'b1;
    wait_done(WRD, 20, cyc); bus.lsb_wr_req = 1'b0;
    checks++; if (cyc !== 5) begin failures++; $display("FAIL b2b_wr_latency: got %0d want 5", cyc); end
    checks++; if (bus.if_done !== 1'b0) begin failures++; $display("FAIL b2b_if_early: got %0b want 0", bus.if_done); end
    checks++;
    if (wlog.size() != 4) begin
      failures++; $display("FAIL b2b_wr_count: got %0d want 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== {32'(32'h100 + i), exp_b[i]}) begin
          failures++; $display("FAIL b2b_wr_byte%0d: got %h:%h want %h:%h", i, wlog[i].a, wlog[i].d, 32'h100 + i, exp_b[i]);
        end
      end
    end
    wait_done(IFD, 10, cyc); bus.if_req = 1'b0;
    checks++; if (cyc !== 2) begin failures++; $display("FAIL b2b_if_latency: got %0d want 2", cyc); end
    checks++; if (bus.if_data !== 32'h03020100) begin failures++; $display("FAIL b2b_if_data: got %h want 03020100", bus.if_data); end
    @(negedge clk);
  endtask

  task automatic test_snoop();
    int cyc;
    wlog.delete();
    bus.lsb_addr = 32'h8; bus.lsb_wdata = 32'hAABBCC55; bus.lsb_len = 3'd1; bus.lsb_wr_req = 1'b1;
    wait_done(WRD, 10, cyc); bus.lsb_wr_req = 1'b0;
    checks++; if (cyc !== 2 || wlog.size() != 1) begin failures++; $display("FAIL snoop_store: latency %0d want 2, writes %0d want 1", cyc, wlog.size()); end
    @(negedge clk);
    bus.if_addr = 32'h8; bus.if_req = 1'b1;
    wait_done(IFD, 40, cyc); bus.if_req = 1'b0;
    checks++; if (cyc !== 18) begin failures++; $display("FAIL snoop_refill_latency: got %0d want 18", cyc); end
    checks++; if (bus.if_data !== 32'h0B0A0955) begin failures++; $display("FAIL snoop_data: got %h want 0b0a0955", bus.if_data); end
    @(negedge clk);
  endtask

  task automatic test_io_stall();
    int cyc, nwr;
    wlog.delete(); nwr = 0;
    io_buffer_full = 1'b1;
    bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h99887766; bus.lsb_len = 3'd2; bus.lsb_wr_req = 1'b1;
    repeat (3) begin @(negedge clk); nwr += int'(bus.mem_wr); end
    checks++; if (nwr !== 0 || wlog.size() != 0) begin failures++; $display("FAIL io_stall_wr: mem_wr cycles %0d writes %0d want 0", nwr, wlog.size()); end
    @(negedge clk); io_buffer_full = 1'b0;
    wait_done(WRD, 10, cyc); bus.lsb_wr_req = 1'b0;
    checks++; if (cyc !== 2) begin failures++; $display("FAIL io_done_latency: got %0d want 2", cyc); end
    checks++;
    if (wlog.size() != 2) begin
      failures++; $display("FAIL io_wr_count: got %0d want 2", wlog.size());
    end else begin
      checks++; if (wlog[0] !== {32'h30000, 8'h66}) begin failures++; $display("FAIL io_byte0: got %h:%h want 30000:66", wlog[0].a, wlog[0].d); end
      checks++; if (wlog[1] !== {32'h30001, 8'h77}) begin failures++; $display("FAIL io_byte1: got %h:%h want 30001:77", wlog[1].a, wlog[1].d); end
    end
    @(negedge clk);
  endtask

  task automatic test_fill_flush();
    int cyc;
    logic seen;
    bus.if_addr = 32'h40; bus.if_req = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (bus.mem_a !== 32'h46) begin failures++; $display("FAIL flush_point: mem_a %h want 46", bus.mem_a); end
    flush = 1'b1; bus.if_req = 1'b0;
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    repeat (25) begin @(negedge clk); seen |= bus.if_done; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done: got %0b want 0", seen); end
    bus.if_addr = 32'h44; bus.if_req = 1'b1;
    wait_done(IFD, 40, cyc); bus.if_req = 1'b0;
    checks++; if (cyc !== 18) begin failures++; $display("FAIL flush_refill_latency: got %0d want 18", cyc); end
    checks++; if (bus.if_data !== 32'h47464544) begin failures++; $display("FAIL flush_refill_data: got %h want 47464544", bus.if_data); end
    checks++; if (bus.mem_a !== 32'h4F) begin failures++; $display("FAIL flush_refill_last_addr: got %h want 4f", bus.mem_a); end
    @(negedge clk);
  endtask

  task automatic test_flush_idle();
    logic seen;
    bus.lsb_addr = 32'h200; bus.lsb_len = 3'd1; bus.lsb_rd_req = 1'b1; flush = 1'b1;
    @(negedge clk); bus.lsb_rd_req = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= bus.lsb_rd_done; end
    checks++; if (seen !== 1'b0 || bus.mem_a !== 32'h4F) begin failures++; $display("FAIL flush_idle: done %0b want 0, mem_a %h want 4f", seen, bus.mem_a); end
  endtask

  task automatic test_load();
    int cyc;
    ram[32'h21] = 8'h34; ram[32'h22] = 8'h12;
    bus.lsb_addr = 32'h21; bus.lsb_len = 3'd2; bus.lsb_rd_req = 1'b1;
    wait_done(RDD, 10, cyc); bus.lsb_rd_req = 1'b0;
    checks++; if (cyc !== 4) begin failures++; $display("FAIL load_latency: got %0d want 4", cyc); end
    checks++; if (bus.lsb_rd_data !== 32'h00001234) begin failures++; $display("FAIL load_data: got %h want 00001234", bus.lsb_rd_data); end
    @(negedge clk);
    bus.lsb_rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk); rdy = 1'b0;
    @(negedge clk);
    @(negedge clk); rdy = 1'b1;
    wait_done(RDD, 10, cyc); bus.lsb_rd_req = 1'b0;
    if (cyc > 0) cyc += 4;
    checks++; if (cyc !== 6) begin failures++; $display("FAIL load_rdy_latency: got %0d want 6", cyc); end
    checks++; if (bus.lsb_rd_data !== 32'h00001234) begin failures++; $display("FAIL load_rdy_data: got %h want 00001234", bus.lsb_rd_data); end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    bus.lsb_rd_req = 1'b0; bus.lsb_wr_req = 1'b0; bus.lsb_len = 3'd1;
    bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.if_req = 1'b0; bus.if_addr = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_fetch_fill();
    test_back_to_back();
    test_snoop();
    test_io_stall();
    test_fill_flush();
    test_flush_idle();
    test_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
